// File: rtl/fibo_pkg.sv
// ============================================================================
// fibo_pkg : constants and types shared by the Fibonacci generator/checker
// Rev 1.0
// ============================================================================
`default_nettype none

package fibo_pkg;

  localparam int FIBO_W = 16;
  localparam logic [FIBO_W-1:0] MAX_FIBO = 16'd46368;
  localparam int FIBO_PERIOD = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

endpackage

`default_nettype wire

// File: rtl/fibo_ref_model.sv
// ============================================================================
// fibo_ref_model : free-running Fibonacci reference (exp/nxt pair)
// Rev 1.0
// ============================================================================
`default_nettype none

module fibo_ref_model
  import fibo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic              advance,
  output logic [FIBO_W-1:0] exp_val,
  output logic              wrap
);

  logic [FIBO_W-1:0] exp_q, exp_d;
  logic [FIBO_W:0]   nxt_q, nxt_d;

  // nxt carries one extra bit: 28657+46368 only ever lands in nxt, never exp
  always_comb begin
    exp_d = exp_q;
    nxt_d = nxt_q;
    wrap  = 1'b0;
    if (restart) begin
      exp_d = '0;
      nxt_d = (FIBO_W+1)'(1);
    end else if (advance) begin
      if (exp_q == MAX_FIBO) begin
        exp_d = '0;
        nxt_d = (FIBO_W+1)'(1);
        wrap  = 1'b1;
      end else begin
        exp_d = nxt_q[FIBO_W-1:0];
        nxt_d = {1'b0, exp_q} + nxt_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      exp_q <= '0;
      nxt_q <= (FIBO_W+1)'(1);
    end else begin
      exp_q <= exp_d;
      nxt_q <= nxt_d;
    end
  end

  assign exp_val = exp_q;

endmodule

`default_nettype wire

// File: rtl/fibonacci_checker.sv
// ============================================================================
// fibonacci_checker : requests Fibonacci beats and checks them against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module fibonacci_checker
  import fibo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  input  logic              f_valid,
  input  logic [FIBO_W-1:0] f_out,
  output logic              f_en,
  output logic              busy,
  output logic [FIBO_W-1:0] last_value,
  output logic [15:0]       term_count,
  output logic [7:0]        wrap_count,
  output logic [7:0]        err_count,
  output logic              error,
  output logic              timeout
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  fsm_state_e        state_q, state_d;
  logic [FIBO_W-1:0] last_value_q, last_value_d;
  logic [15:0]       term_count_q, term_count_d;
  logic [7:0]        wrap_count_q, wrap_count_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              error_q, error_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;

  logic              beat;
  logic [FIBO_W-1:0] ref_exp;
  logic              ref_wrap;

  // clear takes priority over a coincident beat, which is dropped
  assign beat = f_valid && !clear;

  fibo_ref_model u_ref (
    .clock   (clock),
    .reset   (reset),
    .restart (clear),
    .advance (beat),
    .exp_val (ref_exp),
    .wrap    (ref_wrap)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_value_q <= '0;
      term_count_q <= '0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      term_count_q <= term_count_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
      error_q      <= error_d;
      timeout_q    <= timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_REQ;
      ST_REQ:   if (!run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (run)           state_d = ST_REQ;
        else if (!f_valid) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_value_d = last_value_q;
    term_count_d = term_count_q;
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;
    error_d      = error_q;
    timeout_d    = timeout_q;
    tmo_cnt_d    = tmo_cnt_q;
    if (clear) begin
      last_value_d = '0;
      term_count_d = '0;
      wrap_count_d = '0;
      err_count_d  = '0;
      error_d      = 1'b0;
      timeout_d    = 1'b0;
      tmo_cnt_d    = '0;
    end else begin
      if (beat) begin
        last_value_d = f_out;
        term_count_d = term_count_q + 16'd1;
        if (f_out != ref_exp) begin
          error_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        if (ref_wrap && wrap_count_q != 8'hFF) wrap_count_d = wrap_count_q + 8'd1;
      end
      if (state_q != ST_REQ || f_valid) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q < TIMEOUT_C) begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
      if (tmo_cnt_d == TIMEOUT_C) timeout_d = 1'b1;
    end
  end

  always_comb begin
    f_en = (state_q == ST_REQ);
    busy = (state_q != ST_IDLE);
  end

  assign last_value = last_value_q;
  assign term_count = term_count_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;
  assign error      = error_q;
  assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
// ============================================================================
// tb_fibonacci_checker : scoreboard bench with generator model and random run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fibonacci_checker;

  localparam int TMO    = 4;
  localparam int PERIOD = fibo_pkg::FIBO_PERIOD;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        run     = 1'b0;
  logic        clear   = 1'b0;
  logic        f_valid = 1'b0;
  logic [15:0] f_out   = 16'd0;
  logic        f_en, busy, error, timeout;
  logic [15:0] last_value, term_count;
  logic [7:0]  wrap_count, err_count;

  always #5 clock = ~clock;

  fibonacci_checker #(.TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .clear      (clear),
    .f_valid    (f_valid),
    .f_out      (f_out),
    .f_en       (f_en),
    .busy       (busy),
    .last_value (last_value),
    .term_count (term_count),
    .wrap_count (wrap_count),
    .err_count  (err_count),
    .error      (error),
    .timeout    (timeout)
  );

  typedef struct {
    int   last;
    int   term;
    int   wrap;
    int   err;
    logic error;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   fib[PERIOD];

  // stimulus state
  logic rst_r, run_r, clear_r, gen_on, gen_pend, man_valid, corrupt;
  logic [15:0] man_data;
  int   gen_idx;
  // reference: position in the sequence plus running status
  int   m_pos, m_term, m_wrap, m_err, m_last;
  logic m_error;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_zero();
    m_pos = 0; m_term = 0; m_wrap = 0; m_err = 0; m_last = 0; m_error = 1'b0;
  endtask

  // one clock: drive at negedge, update reference, return 1 time unit after posedge
  task automatic step();
    exp_t e;
    @(negedge clock);
    reset = rst_r;
    run   = run_r;
    clear = clear_r;
    if (!rst_r) begin
      gen_pend = 1'b0; gen_idx = 0;
      f_valid  = 1'b0; f_out = 16'd0;
    end else if (gen_on) begin
      f_valid = gen_pend;
      f_out   = 16'd0;
      if (gen_pend) begin
        f_out = 16'(fib[gen_idx]);
        if (corrupt) f_out = f_out ^ 16'h0001;
        gen_idx = (gen_idx + 1) % PERIOD;
      end
      gen_pend = f_en;
      if (clear_r) gen_idx = 0;
    end else begin
      f_valid = man_valid;
      f_out   = man_data;
    end
    if (!rst_r || clear_r) begin
      model_zero();
    end else if (f_valid) begin
      if (int'(f_out) != fib[m_pos]) begin
        m_error = 1'b1;
        if (m_err < 255) m_err++;
      end
      if (m_pos == PERIOD - 1 && m_wrap < 255) m_wrap++;
      m_pos  = (m_pos + 1) % PERIOD;
      m_term = (m_term + 1) % 65536;
      m_last = int'(f_out);
      e.last = m_last; e.term = m_term; e.wrap = m_wrap; e.err = m_err; e.error = m_error;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [15:0] v);
    man_valid = 1'b1; man_data = v;
    step();
    man_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear_r = 1'b1;
    step();
    clear_r = 1'b0;
  endtask

  task automatic attach_gen();
    gen_on = 1'b1; gen_pend = 1'b0; gen_idx = 0;
  endtask

  task automatic wait_term(input int target, input int bound, input string name);
    int n = 0;
    while (term_count != 16'(target) && n < bound) begin
      step();
      n++;
    end
    chk(name, term_count, target);
  endtask

  // monitor: every accepted beat pops one expected status record
  logic mon_rs, mon_cl, mon_fv;
  exp_t mon_e;
  always @(posedge clock) begin
    mon_rs = reset; mon_cl = clear; mon_fv = f_valid;
    #1;
    if (!mon_rs || mon_cl) begin
      chk("zero_last", last_value, 0);
      chk("zero_term", term_count, 0);
      chk("zero_wrap", wrap_count, 0);
      chk("zero_err", err_count, 0);
      chk("zero_error", error, 0);
      chk("zero_timeout", timeout, 0);
      if (!mon_rs) begin
        chk("rst_f_en", f_en, 0);
        chk("rst_busy", busy, 0);
      end
    end else if (mon_fv) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: got beat %0d expected none", f_out);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_last", last_value, mon_e.last);
        chk("sb_term", term_count, mon_e.term);
        chk("sb_wrap", wrap_count, mon_e.wrap);
        chk("sb_err", err_count, mon_e.err);
        chk("sb_error", error, mon_e.error);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i < PERIOD; i++) fib[i] = fib[i-1] + fib[i-2];
    rst_r = 1'b0; run_r = 1'b0; clear_r = 1'b0; gen_on = 1'b0; gen_pend = 1'b0;
    gen_idx = 0; man_valid = 1'b0; man_data = 16'd0; corrupt = 1'b0;
    model_zero();
    step(); step();
    rst_r = 1'b1;

    // continuous run with generator attached
    attach_gen(); run_r = 1'b1;
    step();
    chk("req_f_en", f_en, 1);
    chk("req_busy", busy, 1);
    step();
    chk("first_beat_pending", term_count, 0);
    step();
    chk("first_beat_term", term_count, 1);
    chk("first_beat_val", last_value, 0);
    wait_term(25, 40, "period_term");
    chk("period_last", last_value, 46368);
    chk("period_wrap", wrap_count, 1);
    chk("period_err", err_count, 0);
    chk("period_error", error, 0);
    step();
    chk("after_wrap_val", last_value, 0);
    run_r = 1'b0;
    step();
    chk("fen_fall", f_en, 0);
    chk("drain_busy", busy, 1);
    repeat (3) step();
    chk("idle_busy", busy, 0);

    // run dropped so that the 11th beat lands in DRAIN
    do_clear();
    run_r = 1'b1;
    wait_term(9, 30, "pre_drop_term");
    run_r = 1'b0;
    step();
    chk("drop_f_en", f_en, 0);
    chk("drop_term", term_count, 10);
    step();
    chk("drain_term", term_count, 11);
    step();
    chk("drain_idle", busy, 0);
    chk("drain_final_term", term_count, 11);
    chk("drain_err", err_count, 0);

    // bench-driven beats with one bad term, model keeps its own sequence
    do_clear();
    gen_on = 1'b0;
    beat(16'd0); beat(16'd1); beat(16'd1); beat(16'd2);
    chk("pre_bad_error", error, 0);
    beat(16'd4);
    chk("bad_error", error, 1);
    chk("bad_err", err_count, 1);
    chk("bad_last", last_value, 4);
    beat(16'd8);
    chk("skip_err", err_count, 2);
    beat(16'd8);
    chk("realign_err", err_count, 2);

    // clear coincident with a beat
    clear_r = 1'b1; man_valid = 1'b1; man_data = 16'd13;
    step();
    clear_r = 1'b0; man_valid = 1'b0;
    chk("clr_term", term_count, 0);
    chk("clr_err", err_count, 0);
    beat(16'd0);
    chk("post_clr_term", term_count, 1);
    chk("post_clr_error", error, 0);

    // timeout: run with no beats
    do_clear();
    run_r = 1'b1;
    step();
    chk("tmo_f_en", f_en, 1);
    chk("tmo_start", timeout, 0);
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("tmo_early", timeout, 0);
    end
    step();
    chk("tmo_set", timeout, 1);
    chk("tmo_term", term_count, 0);
    run_r = 1'b0;
    step(); step();
    chk("tmo_idle", busy, 0);
    chk("tmo_sticky", timeout, 1);

    // reset mid-stream
    do_clear();
    attach_gen(); run_r = 1'b1;
    repeat (8) step();
    rst_r = 1'b0;
    step();
    chk("mid_rst_f_en", f_en, 0);
    chk("mid_rst_busy", busy, 0);
    rst_r = 1'b1;
    step();
    chk("rst_resume_f_en", f_en, 1);
    repeat (6) step();
    chk("rst_resume_err", err_count, 0);
    run_r = 1'b0;
    repeat (4) step();

    // error saturation
    do_clear();
    gen_on = 1'b0;
    man_valid = 1'b1; man_data = 16'd7;
    repeat (260) step();
    man_valid = 1'b0;
    chk("err_sat", err_count, 255);
    chk("err_sat_term", term_count, 260);

    // wrap saturation
    do_clear();
    attach_gen(); run_r = 1'b1;
    repeat (256 * PERIOD + 5) step();
    chk("wrap_sat", wrap_count, 255);
    chk("wrap_sat_err", err_count, 0);
    run_r = 1'b0;
    repeat (4) step();

    // randomized run/clear/reset with occasional corrupted beats
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) run_r = ~run_r;
      clear_r = ($urandom_range(29) == 0);
      rst_r   = ($urandom_range(149) != 0);
      corrupt = ($urandom_range(15) == 0);
      step();
    end
    rst_r = 1'b1; clear_r = 1'b0; corrupt = 1'b0; run_r = 1'b0;
    repeat (5) step();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
